// File: rtl/tone_trans_det_if.sv
// Sample/result bundle for tone_trans_det: operands and handshake in, TR/TDP flags out.
// The master drives start/dly_strb and operands; the slave (detector) drives results and status.
interface tone_trans_det_if;
  logic        start;
  logic        dly_strb;
  logic [15:0] DQ;
  logic [18:0] YL;
  logic [15:0] A2;
  logic        TR;
  logic        TDP;
  logic        done;
  logic        busy;
  logic [1:0]  dbg_state;

  // start is a single-cycle request honoured only while busy=0; done pulses once
  // when TR/TDP are valid, and TR/TDP then hold until the next done.
  modport master (
    output start, dly_strb, DQ, YL, A2,
    input  TR, TDP, done, busy, dbg_state
  );
  modport slave (
    input  start, dly_strb, DQ, YL, A2,
    output TR, TDP, done, busy, dbg_state
  );
endinterface

// File: rtl/tone_trans_det.sv
// Tone and transition detector: captures DQ/YL/A2 on start, evaluates in CALC and
// publishes TR/TDP on entry to DONE; TD is the delayed tone flag loaded on dly_strb.
module tone_trans_det #(
  parameter int unsigned YLINT_MAX = 9,
  parameter int unsigned THR_CAP   = 31744
) (
  input  logic             clk,
  input  logic             reset,
  tone_trans_det_if.slave  bus,
  input  logic             test_mode,
  input  logic             scan_enable,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] dqmag_q;
  logic [8:0]  yl_q;
  logic [15:0] a2_q;
  logic        tr_q, tdp_q, td_q;

  logic        cap_en, eval_en;
  logic [3:0]  ylint;
  logic [5:0]  thr_base;
  logic [15:0] thr1, thr2, dqthr;
  logic [16:0] thr_sum;
  logic        tdp_next, tr_next;

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    eval_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cap_en  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        eval_en = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only YL[18:10] feed the threshold, so only those bits are captured.
  assign ylint    = yl_q[8:5];
  assign thr_base = 6'd32 + {1'b0, yl_q[4:0]};
  assign thr1     = {10'd0, thr_base} << ylint;
  assign thr2     = ({28'd0, ylint} > 32'(YLINT_MAX)) ? 16'(THR_CAP) : thr1;
  assign thr_sum  = {1'b0, thr2} + {2'b00, thr2[15:1]};
  assign dqthr    = thr_sum[16:1];
  assign tdp_next = a2_q[15] && (a2_q < 16'hD200);
  assign tr_next  = td_q && ({1'b0, dqmag_q} > dqthr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dqmag_q <= '0;
      yl_q    <= '0;
      a2_q    <= '0;
      tr_q    <= 1'b0;
      tdp_q   <= 1'b0;
      td_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        dqmag_q <= bus.DQ[14:0];
        yl_q    <= bus.YL[18:10];
        a2_q    <= bus.A2;
      end
      if (eval_en) begin
        tr_q  <= tr_next;
        tdp_q <= tdp_next;
      end
      // Reads the pre-edge TR/TDP, so a strobe on the DONE-entry edge sees the old flags.
      if (bus.dly_strb) td_q <= tr_q ? 1'b0 : tdp_q;
    end
  end

  assign bus.TR        = tr_q;
  assign bus.TDP       = tdp_q;
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

  logic scan_path;
  assign scan_path = test_mode & scan_enable;
  assign scan_out0 = scan_path & scan_in0;
  assign scan_out1 = scan_path & scan_in1;
  assign scan_out2 = scan_path & scan_in2;
  assign scan_out3 = scan_path & scan_in3;
  assign scan_out4 = scan_path & scan_in4;

  logic unused_in;
  assign unused_in = ^{bus.DQ[15], bus.YL[9:0]};

endmodule

// File: tb/tb_tone_trans_det.sv
// Bench for tone_trans_det: directed pinned scenarios plus random traffic compared
// every cycle against a cycle-count based model of the detector's rules.
module tb_tone_trans_det;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0, scan_enable = 1'b0;
  logic scan_in0 = 1'b0, scan_in1 = 1'b0, scan_in2 = 1'b0, scan_in3 = 1'b0, scan_in4 = 1'b0;
  logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  tone_trans_det_if bus();

  tone_trans_det dut (
    .clk(clk), .reset(rst_n), .bus(bus),
    .test_mode(test_mode), .scan_enable(scan_enable),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_dqthr(input int yl);
    int ylint, frac, thr;
    ylint = (yl >> 15) & 15;
    frac  = (yl >> 10) & 31;
    thr   = (ylint > 9) ? 31744 : ((32 + frac) << ylint);
    return (thr + thr / 2) / 2;
  endfunction

  function automatic bit model_tone(input int a2);
    return (a2 >= 32768) && (a2 < 53760);
  endfunction

  // k counts clock edges; acc is the edge at which the last start was accepted.
  int          k   = 0;
  int          acc = -100;
  logic [15:0] c_dq = '0;
  logic [18:0] c_yl = '0;
  logic [15:0] c_a2 = '0;
  bit          m_tr = 0, m_tdp = 0, m_td = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= 0;
      acc   <= -100;
      c_dq  <= '0;
      c_yl  <= '0;
      c_a2  <= '0;
      m_tr  <= 0;
      m_tdp <= 0;
      m_td  <= 0;
    end else begin
      k <= k + 1;
      if (bus.dly_strb) m_td <= m_tr ? 1'b0 : m_tdp;
      if (k == acc) begin
        m_tr  <= m_td && (int'(c_dq[14:0]) > model_dqthr(int'(c_yl)));
        m_tdp <= model_tone(int'(c_a2));
      end
      if (bus.start && (k - acc >= 2)) begin
        acc  <= k + 1;
        c_dq <= bus.DQ;
        c_yl <= bus.YL;
        c_a2 <= bus.A2;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_done", int'(bus.done), int'((k - acc) == 1));
    chk("cyc_busy", int'(bus.busy), int'((k - acc) >= 0 && (k - acc) <= 1));
    chk("cyc_tr",   int'(bus.TR),   int'(m_tr));
    chk("cyc_tdp",  int'(bus.TDP),  int'(m_tdp));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit st, input bit strb, input logic [15:0] dq,
                       input logic [18:0] yl, input logic [15:0] a2);
    bus.start    = st;
    bus.dly_strb = strb;
    bus.DQ       = dq;
    bus.YL       = yl;
    bus.A2       = a2;
    @(posedge clk);
    #1;
  endtask

  task automatic run_eval(input string name, input logic [15:0] dq, input logic [18:0] yl,
                          input logic [15:0] a2, input bit exp_tr, input bit exp_tdp);
    int lat;
    lat = -1;
    drive(1, 0, dq, yl, a2);
    for (int i = 0; i < 4 && lat < 0; i++) begin
      drive(0, 0, dq, yl, a2);
      if (bus.done) lat = i;
    end
    chk({name, "_lat"}, lat, 0);
    chk({name, "_tr"}, int'(bus.TR), int'(exp_tr));
    chk({name, "_tdp"}, int'(bus.TDP), int'(exp_tdp));
    drive(0, 0, dq, yl, a2);
  endtask

  int n_done;

  initial begin
    bus.start = 0; bus.dly_strb = 0; bus.DQ = '0; bus.YL = '0; bus.A2 = '0;

    chk("model_thr_yl0", model_dqthr(0), 24);
    chk("model_thr_yl8000", model_dqthr(32'h08000), 48);
    chk("model_thr_cap", model_dqthr(32'h50000), 23808);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tr", int'(bus.TR), 0);
    chk("rst_tdp", int'(bus.TDP), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1;

    // Tone bounds with TD clear
    run_eval("tone_c000", 16'h0000, 19'h0, 16'hC000, 0, 1);
    run_eval("tone_d200", 16'h0000, 19'h0, 16'hD200, 0, 0);
    run_eval("tone_7fff", 16'h0000, 19'h0, 16'h7FFF, 0, 0);
    run_eval("tone_8000", 16'h0000, 19'h0, 16'h8000, 0, 1);

    // Arm TD, then threshold edges at YL=0 (DQTHR=24)
    run_eval("arm", 16'h0000, 19'h0, 16'hC000, 0, 1);
    drive(0, 1, 16'h0000, 19'h0, 16'hC000);
    drive(0, 0, 16'h0000, 19'h0, 16'hC000);
    run_eval("thr_19", 16'h0019, 19'h0, 16'hC000, 1, 1);
    run_eval("thr_18", 16'h0018, 19'h0, 16'hC000, 0, 1);
    run_eval("thr_neg19", 16'h8019, 19'h0, 16'hC000, 1, 1);

    // Capped threshold (DQTHR=23808)
    run_eval("cap_5d01", 16'h5D01, 19'h50000, 16'hC000, 1, 1);
    run_eval("cap_5d00", 16'h5D00, 19'h50000, 16'hC000, 0, 1);

    // Collision: TR=1 before, strobe on the DONE-entry edge clears TD
    run_eval("pre_coll", 16'h5D01, 19'h50000, 16'hC000, 1, 1);
    drive(1, 0, 16'h5D01, 19'h50000, 16'hC000);
    drive(0, 1, 16'h5D01, 19'h50000, 16'hC000);
    chk("coll_done", int'(bus.done), 1);
    chk("coll_tr", int'(bus.TR), 1);
    drive(0, 0, 16'h5D01, 19'h50000, 16'hC000);
    run_eval("post_coll", 16'h5D01, 19'h50000, 16'hC000, 0, 1);

    // Timing: extra start while busy is dropped, start right after DONE is taken
    n_done = 0;
    drive(1, 0, 16'h0000, 19'h0, 16'h8000);
    chk("tim_busy0", int'(bus.busy), 1);
    n_done += int'(bus.done);
    drive(1, 0, 16'h0000, 19'h0, 16'h8000);
    chk("tim_done_n2", int'(bus.done), 1);
    n_done += int'(bus.done);
    drive(0, 0, 16'h0000, 19'h0, 16'h8000);
    chk("tim_idle", int'(bus.busy), 0);
    n_done += int'(bus.done);
    drive(1, 0, 16'h0000, 19'h0, 16'h8000);
    chk("tim_b2b_busy", int'(bus.busy), 1);
    n_done += int'(bus.done);
    drive(0, 0, 16'h0000, 19'h0, 16'h8000);
    chk("tim_b2b_done", int'(bus.done), 1);
    n_done += int'(bus.done);
    drive(0, 0, 16'h0000, 19'h0, 16'h8000);
    n_done += int'(bus.done);
    chk("tim_done_count", n_done, 2);

    // Reset mid-CALC with TR=1 beforehand
    run_eval("rearm", 16'h0000, 19'h0, 16'hC000, 0, 1);
    drive(0, 1, 16'h0000, 19'h0, 16'hC000);
    drive(0, 0, 16'h0000, 19'h0, 16'hC000);
    run_eval("pre_rst", 16'h0019, 19'h0, 16'hC000, 1, 1);
    drive(1, 0, 16'h0019, 19'h0, 16'hC000);
    rst_n = 0;
    #1;
    chk("mid_rst_tr", int'(bus.TR), 0);
    chk("mid_rst_tdp", int'(bus.TDP), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    drive(0, 0, 16'h0019, 19'h0, 16'hC000);
    rst_n = 1;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 16'h0019, 19'h0, 16'hC000);
      n_done += int'(bus.done);
    end
    chk("post_rst_no_done", n_done, 0);

    // Randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] dq, a2;
      logic [18:0] yl;
      dq = 16'(($urandom_range(0, 32767) >> $urandom_range(0, 10)) | (($urandom & 1) << 15));
      yl = 19'(($urandom_range(0, 11) << 15) | $urandom_range(0, 32767));
      a2 = 16'($urandom_range(16'h7000, 16'hE000));
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), dq, yl, a2);
    end

    drive(0, 0, 16'h0, 19'h0, 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tone_trans_det.md
TONE_TRANS_DET -- requirements
Module: tone_trans_det

Interface
REQ-001 Parameter YLINT_MAX, default 9: largest YL integer part that uses the computed threshold.
REQ-002 Parameter THR_CAP, default 31744: threshold THR2 used when YLINT exceeds YLINT_MAX.
REQ-003 clk  in  1  single block clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to evaluate the current sample.
REQ-006 dly_strb  in  1  per-sample delay-update enable, sampled on clk.
REQ-007 DQ  in  16  quantized difference signal, sign-magnitude (bit15 sign, bits14:0 magnitude).
REQ-008 YL  in  19  slow quantizer scale factor, unsigned.
REQ-009 A2  in  16  limited second-order predictor coefficient (A2P) from adap_pred_rec_sig, two's complement.
REQ-010 TR  out  1  transition-detect flag, fed back to the predictor.
REQ-011 TDP  out  1  tone-detect flag for the speed-control stage.
REQ-012 done  out  1  one-cycle pulse marking TR/TDP valid.
REQ-013 busy  out  1  high while state is not IDLE.
REQ-014 test_mode, scan_enable  in  1 each  test controls; no functional effect in this block.
REQ-015 scan_in0..scan_in4  in  1 each  scan chain inputs.
REQ-016 scan_out0..scan_out4  out  1 each  scan chain outputs.

Function
REQ-017 FSM states SHALL be IDLE, CALC and DONE; transitions are IDLE->CALC on start, CALC->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-018 In IDLE with start=1, DQ, YL and A2 SHALL be captured into internal registers; start in CALC or DONE SHALL be ignored with no queuing.
REQ-019 CALC SHALL register DQTHR and TDP_next from the captured operands only; later input changes SHALL have no effect.
REQ-020 YLINT=YL[18:15], YLFRAC=YL[14:10], THR1=(32+YLFRAC)<<YLINT, THR2=(YLINT>YLINT_MAX)?THR_CAP:THR1, and DQTHR=(THR2+(THR2>>1))>>1, computed at 16-bit width without truncation.
REQ-021 DQMAG SHALL be DQ[14:0]; the comparison DQMAG>DQTHR SHALL be unsigned.
REQ-022 TDP_next SHALL be 1 iff 32768<=A2<53760, treating A2 as unsigned 16-bit.
REQ-023 On entry to DONE, TR SHALL equal TD AND (DQMAG>DQTHR), TDP SHALL equal TDP_next, and done=1 for exactly that cycle.
REQ-024 Latency: start sampled in cycle n SHALL give done=1 in cycle n+2.
REQ-025 TR and TDP SHALL hold their values until the next DONE.
REQ-026 On dly_strb=1, TD SHALL be loaded with (TR ? 0 : TDP), using the TR/TDP values present before that edge.
REQ-027 When dly_strb and the DONE-entry update occur on the same edge, TD SHALL use the old TR/TDP, and TR/TDP SHALL take the new values.
REQ-028 busy SHALL be 1 in CALC and DONE and 0 in IDLE.

Reset
REQ-029 While reset=0, state SHALL be IDLE and TR, TDP, done, busy, TD and all captured registers SHALL be 0.
REQ-030 Reset asserted in CALC or DONE SHALL abort the evaluation: no done pulse, and TR/TDP cleared.
REQ-031 After reset is released, the first start SHALL be honoured in the first clock cycle.

Verification
REQ-032 Reset: assert reset=0 mid-CALC -> TR=0, TDP=0, done=0, busy=0 immediately; no later done pulse.
REQ-033 Tone bounds: A2=16'hC000 -> TDP=1; A2=16'hD200 -> TDP=0; A2=16'h7FFF -> TDP=0; A2=16'h8000 -> TDP=1.
REQ-034 Arm TD: A2=16'hC000, DQ=0, start, then dly_strb -> TD=1; next YL=0, DQ=16'h0019 -> TR=1; DQ=16'h0018 -> TR=0 (DQTHR=24); DQ=16'h8019 -> TR=1.
REQ-035 Cap: YL=19'h50000, TD=1 -> DQTHR=23808; DQ=16'h5D01 -> TR=1; DQ=16'h5D00 -> TR=0.
REQ-036 Timing: start in cycle n -> done only in cycle n+2; a start in cycle n+1 is ignored (exactly one done); back-to-back start in cycle n+3 is accepted.
REQ-037 Collision: with TR=1, dly_strb on the DONE-entry edge -> TD=0 (old TR), and TR updates to the new value on the same edge.
